// File: rtl/record_mode.sv
`default_nettype none
// ============================================================================
//  Module      : record_mode
//  Description : Captures live keyboard onsets into a {note, duration} buffer
//                while recording is armed. The read port mirrors the song
//                library: combinational note/duration lookup by note_index,
//                with index 0 always the oldest surviving entry.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                rec_start, rec_stop - single-cycle record control pulses
//                key_on, key         - live keyboard flag and note code
//                note_index          - read address (0 = oldest)
//                note, duration      - combinational read data (0 if invalid)
//                note_count          - number of valid entries (0..DEPTH)
//                recording, full     - registered status flags
//  Options     : REC_LOOP_EN - when defined, a full buffer keeps recording
//                and overwrites the oldest entry; otherwise the commit that
//                fills the buffer ends the recording.
//  Revision    : 1.0 - initial release
// ============================================================================
module record_mode #(
    parameter int DEPTH  = 24,
    parameter int NOTE_W = 4,
    parameter int DUR_W  = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rec_start,
    input  logic              rec_stop,
    input  logic              key_on,
    input  logic [NOTE_W-1:0] key,
    input  logic [4:0]        note_index,
    output logic [NOTE_W-1:0] note,
    output logic [DUR_W-1:0]  duration,
    output logic [4:0]        note_count,
    output logic              recording,
    output logic              full
);

    localparam int              ENTRY_W   = NOTE_W + DUR_W;
    localparam logic [4:0]      c_depth   = 5'(DEPTH);
    localparam logic [4:0]      c_last    = 5'(DEPTH - 1);
    localparam logic [DUR_W-1:0] c_dur_max = '1;

`ifdef REC_LOOP_EN
    localparam bit c_loop = 1'b1;
`else
    localparam bit c_loop = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_NOTE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_prev_key_on;
    logic [NOTE_W-1:0]   r_note;
    logic [DUR_W-1:0]    r_dur_cnt;
    logic [4:0]          r_wr_ptr;
    logic [4:0]          r_count;
    logic                r_recording;
    logic                r_full;
    logic [ENTRY_W-1:0]  r_mem [DEPTH];

    logic                w_onset;
    logic                w_commit;
    logic                w_latch;
    logic                w_clear;
    logic [4:0]          w_next_count;
    logic [4:0]          w_next_ptr;

    // Rising edge of key_on with a real note; code 0 is a rest and ignored.
    assign w_onset = key_on & ~r_prev_key_on & (key != '0);

    always_comb begin
        w_next_state = r_state;
        w_commit     = 1'b0;
        w_latch      = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // rec_stop dominates a simultaneous rec_start.
                if (!rec_stop && rec_start) begin
                    w_next_state = S_ARMED;
                    w_clear      = 1'b1;
                end
            end
            S_ARMED: begin
                if (rec_stop) begin
                    w_next_state = S_IDLE;
                end else if (rec_start) begin
                    w_clear = 1'b1;
                end else if (w_onset) begin
                    w_next_state = S_NOTE;
                    w_latch      = 1'b1;
                end
            end
            S_NOTE: begin
                if (rec_stop) begin
                    // An onset on the same edge is dropped.
                    w_commit     = 1'b1;
                    w_next_state = S_IDLE;
                end else if (rec_start) begin
                    // Open entry is abandoned, not committed.
                    w_next_state = S_ARMED;
                    w_clear      = 1'b1;
                end else if (w_onset) begin
                    w_commit = 1'b1;
                    w_latch  = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // Without looping, the commit that fills the buffer ends recording
        // and any note latched on that edge is thrown away.
        if (!c_loop && w_commit && (r_count == c_last)) begin
            w_next_state = S_IDLE;
            w_latch      = 1'b0;
        end
    end

    always_comb begin
        w_next_count = r_count;
        w_next_ptr   = r_wr_ptr;
        if (w_clear) begin
            w_next_count = '0;
            w_next_ptr   = '0;
        end else if (w_commit) begin
            w_next_ptr = (r_wr_ptr == c_last) ? 5'd0 : r_wr_ptr + 5'd1;
            if (r_count != c_depth) begin
                w_next_count = r_count + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_prev_key_on <= 1'b0;
            r_dur_cnt     <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_recording   <= 1'b0;
            r_full        <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_prev_key_on <= key_on;
            r_wr_ptr      <= w_next_ptr;
            r_count       <= w_next_count;
            r_recording   <= (w_next_state != S_IDLE);
            r_full        <= (w_next_count == c_depth);
            if (w_clear || (w_next_state == S_IDLE)) begin
                r_dur_cnt <= '0;
            end else if (w_latch) begin
                r_dur_cnt <= {{(DUR_W-1){1'b0}}, 1'b1};
            end else if ((r_state == S_NOTE) && (r_dur_cnt != c_dur_max)) begin
                r_dur_cnt <= r_dur_cnt + 1'b1;
            end
        end
    end

    // Storage carries no reset; note_count gates visibility instead.
    always_ff @(posedge clk) begin
        if (!rst && w_latch) begin
            r_note <= key;
        end
        if (!rst && w_commit) begin
            r_mem[r_wr_ptr] <= {r_note, r_dur_cnt};
        end
    end

    // Read port. Once full, wr_ptr points at the oldest entry, so it becomes
    // the base; before that the oldest entry is at address 0.
    logic [4:0]         w_base;
    logic [4:0]         w_room;
    logic [4:0]         w_phys;
    logic               w_valid;
    logic [ENTRY_W-1:0] w_entry;

    assign w_base  = r_full ? r_wr_ptr : 5'd0;
    assign w_room  = c_depth - w_base;
    assign w_phys  = (note_index >= w_room) ? (note_index - w_room)
                                            : (note_index + w_base);
    assign w_valid = (note_index < r_count);
    assign w_entry = r_mem[w_phys];

    assign note       = w_valid ? w_entry[ENTRY_W-1:DUR_W] : '0;
    assign duration   = w_valid ? w_entry[DUR_W-1:0]       : '0;
    assign note_count = r_count;
    assign recording  = r_recording;
    assign full       = r_full;

endmodule
`default_nettype wire

// File: tb/tb_record_mode.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_record_mode
//  Description : Self-checking bench for record_mode: vector table, directed
//                corner sequences and randomized traffic against a
//                timestamp-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_record_mode;

    localparam int DEPTH  = 24;
    localparam int NOTE_W = 4;
    localparam int DUR_W  = 26;

    logic              clk = 1'b0;
    logic              rst;
    logic              rec_start;
    logic              rec_stop;
    logic              key_on;
    logic [NOTE_W-1:0] key;
    logic [4:0]        note_index;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
    logic [4:0]        note_count;
    logic              recording;
    logic              full;

    record_mode #(.DEPTH(DEPTH), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .rec_start  (rec_start),
        .rec_stop   (rec_stop),
        .key_on     (key_on),
        .key        (key),
        .note_index (note_index),
        .note       (note),
        .duration   (duration),
        .note_count (note_count),
        .recording  (recording),
        .full       (full)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    // Entries are kept oldest-first in a queue; durations come from the
    // difference of edge timestamps rather than a running counter.
    typedef struct {
        int n;
        int d;
    } ent_t;

    ent_t    mq[$];
    bit      m_rec;
    bit      m_have;
    int      m_note;
    longint  m_onset_t;
    bit      m_prev;
    longint  cyc = 0;
`ifdef REC_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    function automatic void m_commit();
        ent_t e;
        e.n = m_note;
        e.d = int'(cyc - m_onset_t);
        mq.push_back(e);
        m_have = 0;
        if (mq.size() > DEPTH) void'(mq.pop_front());
        if (!LOOP && mq.size() == DEPTH) m_rec = 0;
    endfunction

    function automatic void model_step();
        bit onset;
        onset = key_on && !m_prev && (key != 0);
        if (rst) begin
            mq.delete();
            m_rec = 0; m_have = 0; m_prev = 0;
            return;
        end
        if (rec_stop) begin
            if (m_have) m_commit();
            m_rec = 0; m_have = 0;
        end else if (rec_start) begin
            mq.delete();
            m_rec = 1; m_have = 0;
        end else if (m_rec && onset) begin
            if (m_have) m_commit();
            if (m_rec) begin
                m_have = 1; m_note = int'(key); m_onset_t = cyc;
            end
        end
        m_prev = key_on;
    endfunction

    function automatic void model_read(int idx, output int n, output int d);
        if (idx < mq.size()) begin n = mq[idx].n; d = mq[idx].d; end
        else begin n = 0; d = 0; end
    endfunction

    task automatic tick();
        int ri, en, ed;
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        chk("count_vs_model", note_count, mq.size());
        chk("recording_vs_model", recording, m_rec);
        chk("full_vs_model", full, mq.size() == DEPTH);
        ri = $urandom_range(0, 31);
        note_index = 5'(ri);
        #0.01;
        model_read(ri, en, ed);
        chk("read_note_vs_model", note, en);
        chk("read_dur_vs_model", duration, ed);
    endtask

    task automatic idle(int n);
        rec_start = 0; rec_stop = 0; key_on = 0; key = 0;
        repeat (n) tick();
    endtask

    task automatic check_entry(string name, int idx, int n, int d);
        note_index = 5'(idx);
        #0.01;
        chk({name, "_note"}, note, n);
        chk({name, "_dur"}, duration, d);
    endtask

    task automatic pulse_start();
        rec_start = 1; tick(); rec_start = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit rst, rs, rp, kon;
        int key;
        int cnt;
        bit rec, fl;
        int n0, d0;
    } vec_t;

    vec_t vt[13];

    initial begin
        rst = 1; rec_start = 0; rec_stop = 0; key_on = 0; key = 0; note_index = 0;
        m_rec = 0; m_have = 0; m_prev = 0; m_note = 0; m_onset_t = 0;

        //            rst rs rp kon key cnt rec fl  n0 d0
        vt[0]  = '{1'b1,1'b0,1'b0,1'b0, 0, 0, 1'b0,1'b0, 0, 0};
        vt[1]  = '{1'b0,1'b0,1'b0,1'b0, 0, 0, 1'b0,1'b0, 0, 0};
        vt[2]  = '{1'b0,1'b1,1'b0,1'b0, 0, 0, 1'b1,1'b0, 0, 0};
        vt[3]  = '{1'b0,1'b0,1'b0,1'b1, 0, 0, 1'b1,1'b0, 0, 0};
        vt[4]  = '{1'b0,1'b0,1'b0,1'b0, 0, 0, 1'b1,1'b0, 0, 0};
        vt[5]  = '{1'b0,1'b0,1'b0,1'b1, 3, 0, 1'b1,1'b0, 0, 0};
        vt[6]  = '{1'b0,1'b0,1'b0,1'b1, 3, 0, 1'b1,1'b0, 0, 0};
        vt[7]  = '{1'b0,1'b0,1'b0,1'b0, 0, 0, 1'b1,1'b0, 0, 0};
        vt[8]  = '{1'b0,1'b0,1'b0,1'b1, 7, 1, 1'b1,1'b0, 3, 3};
        vt[9]  = '{1'b0,1'b0,1'b1,1'b0, 0, 2, 1'b0,1'b0, 3, 3};
        vt[10] = '{1'b0,1'b1,1'b1,1'b0, 0, 2, 1'b0,1'b0, 3, 3};
        vt[11] = '{1'b0,1'b1,1'b0,1'b0, 0, 0, 1'b1,1'b0, 0, 0};
        vt[12] = '{1'b0,1'b0,1'b1,1'b1, 4, 0, 1'b0,1'b0, 0, 0};

        for (int i = 0; i < 13; i++) begin
            rst = vt[i].rst; rec_start = vt[i].rs; rec_stop = vt[i].rp;
            key_on = vt[i].kon; key = 4'(vt[i].key);
            tick();
            chk($sformatf("vec%0d_count", i), note_count, vt[i].cnt);
            chk($sformatf("vec%0d_recording", i), recording, vt[i].rec);
            chk($sformatf("vec%0d_full", i), full, vt[i].fl);
            check_entry($sformatf("vec%0d_idx0", i), 0, vt[i].n0, vt[i].d0);
        end
        idle(2);

        // Two onsets 100 apart, stop 150 after the second.
        pulse_start();
        key_on = 1; key = 3; tick();
        idle(99);
        key_on = 1; key = 5; tick();
        idle(149);
        rec_stop = 1; tick(); rec_stop = 0;
        chk("two_notes_count", note_count, 2);
        chk("two_notes_recording", recording, 0);
        check_entry("two_notes_e0", 0, 3, 100);
        check_entry("two_notes_e1", 1, 5, 150);
        check_entry("two_notes_e2", 2, 0, 0);

        // Key-0 onset ignored; single note held 1000 cycles.
        pulse_start();
        key_on = 1; key = 0; tick();
        idle(3);
        key_on = 1; key = 9; tick();
        repeat (999) tick();
        rec_stop = 1; tick();
        idle(1);
        chk("held_count", note_count, 1);
        check_entry("held_e0", 0, 9, 1000);

        // Fill: 25 onsets spaced 10 cycles apart, then stop.
        pulse_start();
        for (int i = 0; i < 25; i++) begin
            key_on = 1; key = 4'((i % 15) + 1); tick();
            idle(9);
        end
`ifndef REC_LOOP_EN
        chk("fill_full", full, 1);
        chk("fill_recording", recording, 0);
        chk("fill_count", note_count, 24);
        check_entry("fill_e0", 0, 1, 10);
        check_entry("fill_e23", 23, 9, 10);
`endif
        rec_stop = 1; tick(); rec_stop = 0;
        key_on = 1; key = 6; tick();
        idle(5);
        chk("fill_after_count", note_count, 24);
        chk("fill_after_full", full, 1);
`ifdef REC_LOOP_EN
        check_entry("loop_e0", 0, 2, 10);
        check_entry("loop_e23", 23, 10, 10);
`else
        check_entry("fill_after_e0", 0, 1, 10);
`endif

        // Onset coinciding with stop: only the open entry is committed.
        pulse_start();
        key_on = 1; key = 2; tick();
        idle(5);
        key_on = 1; key = 6; rec_stop = 1; tick();
        idle(2);
        chk("onset_stop_count", note_count, 1);
        check_entry("onset_stop_e0", 0, 2, 6);

        // Reset mid-note, then a fresh single-entry recording.
        pulse_start();
        key_on = 1; key = 4; tick();
        idle(3);
        rst = 1; tick(); rst = 0;
        chk("rst_mid_count", note_count, 0);
        chk("rst_mid_recording", recording, 0);
        check_entry("rst_mid_e0", 0, 0, 0);
        pulse_start();
        key_on = 1; key = 8; tick();
        idle(2);
        rec_stop = 1; tick(); rec_stop = 0;
        chk("rst_after_count", note_count, 1);
        check_entry("rst_after_e0", 0, 8, 3);
        check_entry("rst_after_e1", 1, 0, 0);

        // Randomized traffic checked every cycle against the model.
        idle(1);
        for (int i = 0; i < 6000; i++) begin
            rst       = ($urandom_range(0, 499) == 0);
            rec_start = ($urandom_range(0, 149) == 0);
            rec_stop  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) key_on = ~key_on;
            key = 4'($urandom_range(0, 15));
            tick();
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
